// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [5:0]  OPC_HALT = 6'b010001;
  localparam logic [31:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } if_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP,
    S_HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] inst);
    return inst[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_stage_fifo.sv
// Prefetch buffer: synchronous FIFO of {inst, pc4}; flush beats push and pop.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  if_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output if_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch FSM, prefetch FIFO, ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  if_stage_if.master        imem,
  input  logic              stall_f_id,
  input  logic              redirect_f_ex,
  input  logic [31:0]       redirect_pc_f_ex,
  output logic [31:0]       inst_2_id,
  output logic [31:0]       pc4_in_2_id,
  output logic              valid_2_id,
  output logic              halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc;
  if_entry_t     rsp_entry;
  if_entry_t     fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          issue;
  logic          rsp_accept;
  logic          out_load;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;

  // pc already advanced past the outstanding fetch, so it is that word's pc+4.
  assign rsp_entry  = '{inst: imem.imem_rdata, pc4: pc};
  assign rsp_accept = (state == S_WAIT) && imem.imem_rvalid && !redirect_f_ex;
  assign out_load   = !redirect_f_ex && !stall_f_id;
  assign bypass     = out_load && fifo_empty && rsp_accept;
  assign fifo_push  = rsp_accept && !bypass && !fifo_full;
  assign fifo_pop   = out_load && !fifo_empty;
  assign issue      = reset && (state == S_IDLE) && !redirect_f_ex &&
                      (fifo_count < CW'(FIFO_DEPTH));

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .flush     (redirect_f_ex),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= PC_RESET;
    end else if (redirect_f_ex) begin
      pc <= redirect_pc_f_ex & 32'hFFFF_FFFC;
      // A still-outstanding response must be swallowed before fetching again.
      if ((state == S_WAIT || state == S_DROP) && !imem.imem_rvalid) state <= S_DROP;
      else                                                          state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (issue) begin
          pc    <= pc + 32'd4;
          state <= S_WAIT;
        end
        S_WAIT: if (imem.imem_rvalid) state <= is_halt(imem.imem_rdata) ? S_HALT : S_IDLE;
        S_DROP: if (imem.imem_rvalid) state <= S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_2_id   <= NOP_INST;
      pc4_in_2_id <= '0;
      valid_2_id  <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_f_ex) begin
      inst_2_id   <= NOP_INST;
      pc4_in_2_id <= '0;
      valid_2_id  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (!stall_f_id) begin
        if (!fifo_empty) begin
          inst_2_id   <= fifo_head.inst;
          pc4_in_2_id <= fifo_head.pc4;
          valid_2_id  <= 1'b1;
        end else if (rsp_accept) begin
          inst_2_id   <= rsp_entry.inst;
          pc4_in_2_id <= rsp_entry.pc4;
          valid_2_id  <= 1'b1;
        end else begin
          inst_2_id   <= NOP_INST;
          pc4_in_2_id <= '0;
          valid_2_id  <= 1'b0;
        end
      end
      if (valid_2_id && is_halt(inst_2_id)) halted <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic bubble_now;
  assign bubble_now = !stall_f_id && (redirect_f_ex || (fifo_empty && !rsp_accept));

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (rsp_accept && perf_fetch_cnt != '1)  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_now && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table of fetch runs plus stall/redirect/halt/reset sequences.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  if_stage_if imem ();

  if_stage #(.PC_RESET(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem             (imem),
    .stall_f_id       (stall),
    .redirect_f_ex    (redirect),
    .redirect_pc_f_ex (rpc),
    .inst_2_id        (inst),
    .pc4_in_2_id      (pc4),
    .valid_2_id       (valid),
    .halted           (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_bubble_cnt  (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: fixed latency, one response per request, word derived from the address.
  int unsigned lat = 1;
  int unsigned cnt = 0;
  bit          pend = 1'b0;
  bit          hold_resp = 1'b0;
  bit          halt_en = 1'b0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [29:0] idx;
    logic [29:0] nxt;
    idx = a[31:2];
    nxt = idx + 30'd1;
    if (halt_en && a == 32'hC) return 32'h4400_0000;
    return {6'(idx % 30'd15) + 6'd1, nxt[25:0]};
  endfunction

  always @(negedge clk) begin
    imem.imem_rvalid = 1'b0;
    if (!reset && !hold_resp) pend = 1'b0;
    else if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = word_at(paddr);
        pend = 1'b0;
      end
    end
    if (imem.imem_req) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem.imem_addr;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset, then redirect in the first post-reset cycle; returns at the start of cycle 0.
  task automatic start(input logic [31:0] target, input int unsigned l, input logic st);
    cyc(); reset = 1'b0; redirect = 1'b0; stall = 1'b0;
    cyc();
    cyc(); reset = 1'b1; redirect = 1'b1; rpc = target; lat = l;
    cyc(); redirect = 1'b0; stall = st;
  endtask

  typedef struct {
    logic [31:0] target;
    int unsigned l;
    int unsigned exp_lat;
    logic [31:0] pc4_0;
    logic [31:0] inst_0;
    logic [31:0] pc4_1;
    logic [31:0] inst_1;
  } vec_t;

  vec_t        vt [5];
  int          got;
  int          first_k;
  int          ks [3];
  logic [31:0] g_pc4 [3];
  logic [31:0] g_inst [3];
  int          nreq;
  bit          hold_ok;
  bit          trig;
  bit          redir_done;
  int          rk;
  bit          have_req;
  bit          have_out;
  logic [31:0] req_after;
  logic [31:0] out_pc4;
  logic [31:0] out_inst;
  int          stale;
  logic [31:0] last_addr;
  int          kh;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{32'h0000_0000, 1, 2, 32'h4,   32'h0400_0001, 32'h8,   32'h0800_0002};
    vt[1] = '{32'h0000_0100, 1, 2, 32'h104, 32'h1400_0041, 32'h108, 32'h1800_0042};
    vt[2] = '{32'h0000_0103, 3, 4, 32'h104, 32'h1400_0041, 32'h108, 32'h1800_0042};
    vt[3] = '{32'hFFFF_FFFC, 2, 3, 32'h0,   32'h1000_0000, 32'h4,   32'h0400_0001};
    vt[4] = '{32'h0000_0020, 1, 2, 32'h24,  32'h2400_0009, 32'h28,  32'h2800_000A};

    // Reset values
    cyc(); reset = 1'b0;
    cyc();
    @(negedge clk);
    check("rst_req",    32'(imem.imem_req), 32'h0);
    check("rst_addr",   imem.imem_addr, 32'h0);
    check("rst_inst",   inst, 32'h0);
    check("rst_pc4",    pc4, 32'h0);
    check("rst_valid",  32'(valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // Vector table: fetch from a redirect target, first two outputs and latency
    for (int i = 0; i < 5; i++) begin
      start(vt[i].target, vt[i].l, 1'b0);
      got = 0; first_k = 999;
      for (int j = 0; j < 3; j++) begin g_pc4[j] = 32'hDEAD_BEEF; g_inst[j] = 32'hDEAD_BEEF; end
      for (int k = 0; k < 40 && got < 2; k++) begin
        @(negedge clk);
        if (valid) begin
          if (got == 0) first_k = k;
          g_pc4[got] = pc4; g_inst[got] = inst; got++;
        end
        cyc();
      end
      check($sformatf("v%0d_lat", i),   32'(first_k), 32'(vt[i].exp_lat));
      check($sformatf("v%0d_pc4_0", i), g_pc4[0],  vt[i].pc4_0);
      check($sformatf("v%0d_inst_0", i), g_inst[0], vt[i].inst_0);
      check($sformatf("v%0d_pc4_1", i), g_pc4[1],  vt[i].pc4_1);
      check($sformatf("v%0d_inst_1", i), g_inst[1], vt[i].inst_1);
    end

    // Stall: FIFO fills with exactly two words, then drains in order without gaps
    start(32'h0, 1, 1'b1);
    nreq = 0; hold_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem.imem_req) nreq++;
      if (valid || inst != 32'h0) hold_ok = 1'b0;
      cyc();
      if (k == 5) stall = 1'b0;
    end
    check("stall_reqs", 32'(nreq), 32'd2);
    check("stall_hold", 32'(hold_ok), 32'd1);
    got = 0;
    for (int j = 0; j < 3; j++) begin g_pc4[j] = 32'hDEAD_BEEF; ks[j] = -1; end
    for (int k = 6; k < 30 && got < 3; k++) begin
      @(negedge clk);
      if (valid) begin ks[got] = k; g_pc4[got] = pc4; got++; end
      cyc();
    end
    check("drain_pc4_0", g_pc4[0], 32'h4);
    check("drain_pc4_1", g_pc4[1], 32'h8);
    check("drain_pc4_2", g_pc4[2], 32'hC);
    check("drain_k0", 32'(ks[0]), 32'd7);
    check("drain_k2", 32'(ks[2]), 32'd9);

    // Redirect while the fetch of 0x8 is outstanding
    start(32'h0, 2, 1'b0);
    trig = 0; redir_done = 0; rk = 0; have_req = 0; have_out = 0; stale = 0;
    req_after = 32'hDEAD_BEEF; out_pc4 = 32'hDEAD_BEEF; out_inst = 32'hDEAD_BEEF;
    for (int k = 0; k < 40 && !(have_req && have_out); k++) begin
      @(negedge clk);
      if (redir_done && k > rk) begin
        if (imem.imem_req && !have_req) begin req_after = imem.imem_addr; have_req = 1; end
        if (valid && !have_out) begin out_pc4 = pc4; out_inst = inst; have_out = 1; end
      end
      if (valid && pc4 == 32'hC) stale++;
      if (!redir_done && imem.imem_req && imem.imem_addr == 32'h8) trig = 1;
      cyc();
      redirect = 1'b0;
      if (trig) begin redirect = 1'b1; rpc = 32'h100; redir_done = 1; rk = k + 1; trig = 0; end
    end
    check("redir_addr", req_after, 32'h100);
    check("redir_pc4",  out_pc4, 32'h104);
    check("redir_inst", out_inst, 32'h1400_0041);
    check("redir_stale", 32'(stale), 32'd0);

    // HALT word at 0xC stops fetching; redirect resumes
    halt_en = 1'b1;
    start(32'h0, 1, 1'b0);
    nreq = 0; last_addr = 32'hDEAD_BEEF; kh = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem.imem_req) begin nreq++; last_addr = imem.imem_addr; end
      if (kh >= 0 && k == kh + 1) check("halted_set", 32'(halted), 32'd1);
      if (valid && pc4 == 32'h10 && kh < 0) begin
        kh = k;
        check("halt_inst", inst, 32'h4400_0000);
        check("halted_early", 32'(halted), 32'd0);
      end
      cyc();
    end
    check("halt_seen", 32'(kh >= 0), 32'd1);
    check("halt_nreq", 32'(nreq), 32'd4);
    check("halt_last", last_addr, 32'hC);
    check("halted_hold", 32'(halted), 32'd1);
    redirect = 1'b1; rpc = 32'h20;
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_req", 32'(imem.imem_req), 32'd1);
    check("resume_addr", imem.imem_addr, 32'h20);
    halt_en = 1'b0;

    // Reset during WAIT; the stale response lands in the first cycle after reset
    hold_resp = 1'b1;
    start(32'h0, 2, 1'b0);
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    @(negedge clk);
    check("wrst_inst",  inst, 32'h0);
    check("wrst_pc4",   pc4, 32'h0);
    check("wrst_valid", 32'(valid), 32'd0);
    check("wrst_req",   32'(imem.imem_req), 32'd1);
    check("wrst_addr",  imem.imem_addr, 32'h0);
    cyc();
    @(negedge clk);
    check("wrst_ignore", 32'(valid), 32'd0);
    got = 0; first_k = 999; g_pc4[0] = 32'hDEAD_BEEF; g_inst[0] = 32'hDEAD_BEEF;
    for (int k = 3; k < 20 && got < 1; k++) begin
      cyc();
      @(negedge clk);
      if (valid) begin first_k = k + 1; g_pc4[0] = pc4; g_inst[0] = inst; got++; end
    end
    check("wrst_k",    32'(first_k), 32'd5);
    check("wrst_pc4_0", g_pc4[0], 32'h4);
    check("wrst_inst_0", g_inst[0], 32'h0400_0001);
    hold_resp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
